mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//   Shares the single-port MIPS byte-addressed memory between instruction fetch (I, read-only) and load/store (D).
//   Accepts one valid/ready request per port and issues one access at a time to the memory.
//   Returns read data, or a write acknowledge, to the originating port.
//   Sits between the core's fetch/mem stages and the mem block; it is the only driver of mem's write/addr/wdata.
// PARAMETERS
//   AW        32  address width, matches mem addr port
//   DW        32  data width, matches mem wdata/rdata
// PORTS
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   i_req_valid  in   1   fetch request present
//   i_req_ready  out  1   fetch request accepted this cycle (when valid & ready)
//   i_req_addr   in   AW  fetch byte address
//   i_rsp_valid  out  1   one-cycle pulse: i_rsp_rdata valid
//   i_rsp_rdata  out  DW  fetched word
//   d_req_valid  in   1   load/store request present
//   d_req_ready  out  1   load/store request accepted this cycle
//   d_req_write  in   1   1 = store, 0 = load
//   d_req_addr   in   AW  load/store byte address
//   d_req_wdata  in   DW  store data
//   d_rsp_valid  out  1   one-cycle pulse: load data valid / store complete
//   d_rsp_rdata  out  DW  load data (0 for stores)
//   mem_write    out  1   to mem.write
//   mem_addr     out  AW  to mem.addr
//   mem_wdata    out  DW  to mem.wdata
//   mem_rdata    in   DW  from mem.rdata (registered in mem, valid 1 cycle after addr)
//   busy         out  1   state != IDLE
// BEHAVIOUR
//   FSM states: IDLE, ISSUE, RESP. Reset -> IDLE.
//   - IDLE: both readys follow grant logic. On accept, latch port id, write, addr, wdata; -> ISSUE. Otherwise stay.
//   - ISSUE (1 cycle): drive mem_* from latched registers only; mem_write = latched write. -> RESP.
//   - RESP (1 cycle): pulse rsp_valid on the latched port; rsp_rdata = mem_rdata for a read, 0 for a write.
//     New accept allowed -> ISSUE; else -> IDLE.
//   Latency: accept at edge T; mem access during cycle T+1; rsp_valid during cycle T+2. Peak throughput 1 access per 2 cycles.
//   Readys: low in ISSUE. At most one of i_req_ready/d_req_ready is high in any cycle.
//     A ready is never high unless its valid is high, so readys are combinational on valids.
//   Default grant: fixed priority, D over I (drains older pipeline stage first).
//   No response backpressure: the requester must take rsp_valid on the cycle it pulses.
//   Outside ISSUE:
//     - mem_write = 0 (mem writes combinationally, so a glitch-free write window is mandatory).
//     - mem_addr and mem_wdata hold their last latched values.
//   Addresses pass through unmodified; no alignment or bounds check.
//   Reset values: all readys 0, rsp_valids 0, rsp_rdatas 0, mem_write 0, mem_addr 0, mem_wdata 0, busy 0, latched regs 0.
//   Reset mid-transaction: the access is abandoned, no rsp_valid is issued, FSM -> IDLE.
//     Any store already committed to mem remains.
//   Request dropped while not ready: no effect; the requester may change addr freely until accepted.
// CONFIGURATION
//   MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous I and D valid, grant the port not granted last.
//     A last-grant flop resets to I, so the first contention grants D; it updates on every accept.
//   Undefined: fixed D-over-I priority; no last-grant flop exists.
//   A single valid requester is always granted in both modes.
// STRUCTURE
//   mem_arb_pkg:
//     - state enum {IDLE, ISSUE, RESP}
//     - port id constants PORT_I = 1'b0, PORT_D = 1'b1
//     - shared by core and bench
//   Sub-module mem_arb_pick: combinational grant logic.
//     - Inputs: i_valid, d_valid, can_accept, last_grant.
//     - Outputs: i_grant, d_grant.
//     - The only place the macro is tested.
//   The top module holds the FSM, request latches and response muxing.
// TESTING (bench pairs with mem, MEMSIZE=1024)
//   Store D addr=0x10 wdata=0xDEADBEEF, then load D addr=0x10
//     -> d_rsp_valid at T+2 for each; load data 0xDEADBEEF.
//   Fetch I addr=0x10 alone -> i_req_ready same cycle; i_rsp_valid exactly 2 cycles later;
//     rdata 0xDEADBEEF; d_rsp_valid stays 0.
//   I and D valid together for 4 accepts:
//     - default: D,D,D,D while D stays valid, I starved.
//     - RR_EN: D,I,D,I.
//   Back-to-back D loads 0x0, 0x4, 0x8 held valid -> accepts every 2 cycles, responses in order;
//     mem_write never high.
//   Assert rst_n low during ISSUE of a load -> no rsp_valid; all outputs 0 asynchronously; next request serviced normally.
//   Assertions throughout:
//     - mem_write only in ISSUE
//     - never both readys high
//     - exactly one rsp_valid per accept

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Used by the arbiter RTL and by its bench.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between fetch (I) and load/store (D) requesters.
// MEM_ARB_ROUND_ROBIN_EN selects alternating grants on contention; otherwise D wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_valid,
    input  logic d_valid,
    input  logic can_accept,
    input  logic last_grant,
    output logic i_grant,
    output logic d_grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        i_grant = 1'b0;
        d_grant = 1'b0;
        if (can_accept) begin
            if (i_valid && d_valid) begin
                if (last_grant == PORT_I) begin
                    d_grant = 1'b1;
                end else begin
                    i_grant = 1'b1;
                end
            end else begin
                i_grant = i_valid;
                d_grant = d_valid;
            end
        end
    end
`else
    // Fixed priority ignores grant history; the upstream flop is trimmed away.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        i_grant = 1'b0;
        d_grant = 1'b0;
        if (can_accept) begin
            d_grant = d_valid;
            i_grant = i_valid && !d_valid;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: one access at a time, I (fetch) vs D (load/store).
// Grant policy set by MEM_ARB_ROUND_ROBIN_EN inside mem_arb_pick.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req_valid,
    output logic          i_req_ready,
    input  logic [AW-1:0] i_req_addr,
    output logic          i_rsp_valid,
    output logic [DW-1:0] i_rsp_rdata,
    input  logic          d_req_valid,
    output logic          d_req_ready,
    input  logic          d_req_write,
    input  logic [AW-1:0] d_req_addr,
    input  logic [DW-1:0] d_req_wdata,
    output logic          d_rsp_valid,
    output logic [DW-1:0] d_rsp_rdata,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    state_e        state_q, state_d;
    logic          port_q, port_d;
    logic          write_q, write_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          last_q, last_d;

    logic can_accept;
    logic i_grant, d_grant, accept;

    // Reset gates acceptance so readys are low while rst_n is asserted.
    assign can_accept = rst_n && (state_q != ISSUE);
    assign accept     = i_grant || d_grant;

    mem_arb_pick u_pick (
        .i_valid    (i_req_valid),
        .d_valid    (d_req_valid),
        .can_accept (can_accept),
        .last_grant (last_q),
        .i_grant    (i_grant),
        .d_grant    (d_grant)
    );

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        last_d  = last_q;

        case (state_q)
            IDLE:    state_d = accept ? ISSUE : IDLE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = accept ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            port_d  = d_grant ? PORT_D : PORT_I;
            write_d = d_grant && d_req_write;
            addr_d  = d_grant ? d_req_addr : i_req_addr;
            last_d  = d_grant ? PORT_D : PORT_I;
            if (d_grant) begin
                wdata_d = d_req_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            port_q  <= PORT_I;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            last_q  <= PORT_I;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
        end
    end

    // mem writes combinationally, so the write strobe exists only in ISSUE.
    always_comb begin
        i_req_ready = i_grant;
        d_req_ready = d_grant;
        mem_write   = (state_q == ISSUE) && write_q;
        mem_addr    = addr_q;
        mem_wdata   = wdata_q;
        busy        = (state_q != IDLE);
        i_rsp_valid = 1'b0;
        d_rsp_valid = 1'b0;
        i_rsp_rdata = '0;
        d_rsp_rdata = '0;
        if (state_q == RESP) begin
            if (port_q == PORT_D) begin
                d_rsp_valid = 1'b1;
                d_rsp_rdata = write_q ? '0 : mem_rdata;
            end else begin
                i_rsp_valid = 1'b1;
                i_rsp_rdata = mem_rdata;
            end
        end
    end

endmodule
